// File: rtl/stack_if.sv
// Stack request/status bundle: the master drives push/pop/di, the stack returns its
// pointer, full/empty/error flags and registered pop data.
interface stack_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned WL = 3
);
  logic          push;
  logic          pop;
  logic [WL-1:0] di;
  logic [N-1:0]  sp;
  logic          full;
  logic          empty;
  logic          error;
  logic [WL-1:0] data;

  modport master (
    output push, pop, di,
    input  sp, full, empty, error, data
  );

  modport slave (
    input  push, pop, di,
    output sp, full, empty, error, data
  );
endinterface

// File: rtl/stack.sv
// N-deep LIFO of WL-bit words with registered pop data and an illegal-operation flag.
// Define STACK_ERR_STICKY_EN to make the error flag sticky until reset.
module stack #(
  parameter int unsigned N  = 4,
  parameter int unsigned WL = 3
) (
  input logic     CLK,
  input logic     RESET,
  stack_if.slave  bus
);
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  logic [WL-1:0] r_mem [N];
  logic [N-1:0]  r_sp;
  logic [WL-1:0] r_data;
  logic          r_error;

  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_we;
  logic          w_rd;
  logic          w_illegal;
  logic [N-1:0]  w_sp_d;

  assign w_full    = (r_sp == N'(N));
  assign w_empty   = (r_sp == '0);
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);

  always_comb begin
    w_we      = 1'b0;
    w_rd      = 1'b0;
    w_illegal = 1'b0;
    w_wr_idx  = r_sp[AW-1:0];
    w_sp_d    = r_sp;
    if (bus.push && bus.pop) begin
      if (w_empty) begin
        // Push still happens on an empty stack; only the pop half is illegal.
        w_we      = 1'b1;
        w_illegal = 1'b1;
        w_sp_d    = N'(1);
      end else begin
        w_we     = 1'b1;
        w_rd     = 1'b1;
        w_wr_idx = w_top_idx;
      end
    end else if (bus.push) begin
      if (w_full) begin
        w_illegal = 1'b1;
      end else begin
        w_we   = 1'b1;
        w_sp_d = r_sp + N'(1);
      end
    end else if (bus.pop) begin
      if (w_empty) begin
        w_illegal = 1'b1;
      end else begin
        w_rd   = 1'b1;
        w_sp_d = r_sp - N'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_wr_idx] <= bus.di;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sp    <= '0;
      r_data  <= '0;
      r_error <= 1'b0;
    end else begin
      r_sp <= w_sp_d;
      if (w_rd) begin
        r_data <= r_mem[w_top_idx];
      end
`ifdef STACK_ERR_STICKY_EN
      r_error <= r_error | w_illegal;
`else
      r_error <= w_illegal;
`endif
    end
  end

  assign bus.sp    = r_sp;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.error = r_error;
  assign bus.data  = r_data;
endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack: directed scenarios plus random traffic against a
// queue-based LIFO model.
module tb_stack;
  localparam int unsigned N  = 4;
  localparam int unsigned WL = 3;
  localparam int unsigned VW = N + 3 + WL;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;

  logic [WL-1:0] q[$];
  logic [WL-1:0] m_data;
  logic          m_err;

  stack_if #(.N(N), .WL(WL)) bus ();

  stack #(.N(N), .WL(WL)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [VW-1:0] exp_vec();
    return {N'(q.size()), q.size() == N, q.size() == 0, m_err, m_data};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.sp, bus.full, bus.empty, bus.error, bus.data};
  endfunction

  // Drive one operation for one clock edge and advance the reference model.
  task automatic step(input logic p, input logic o, input logic [WL-1:0] d);
    logic ill;
    @(negedge CLK);
    bus.push = p;
    bus.pop  = o;
    bus.di   = d;
    @(posedge CLK);
    ill = 1'b0;
    if (p && o) begin
      if (q.size() == 0) begin
        q.push_back(d);
        ill = 1'b1;
      end else begin
        m_data = q[$];
        q[$]   = d;
      end
    end else if (p) begin
      if (q.size() == N) ill = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) ill = 1'b1;
      else m_data = q.pop_back();
    end
`ifdef STACK_ERR_STICKY_EN
    m_err = m_err | ill;
`else
    m_err = ill;
`endif
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic test_reset();
    RESET    = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.di   = '0;
    q.delete();
    m_data = '0;
    m_err  = 1'b0;
    #12;
    n_checks++;
    if (act_vec() !== {N'(0), 1'b0, 1'b1, 1'b0, WL'(0)}) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", act_vec(), {N'(0), 1'b0, 1'b1, 1'b0, WL'(0)});
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_fill();
    logic [WL-1:0] vals[4] = '{3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, vals[i]);
      n_checks++;
      if (act_vec() !== exp_vec() || bus.sp !== N'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0 || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_flags: got full=%b empty=%b err=%b want 1 0 0",
               bus.full, bus.empty, bus.error);
    end
  endtask

  task automatic test_overflow();
    logic [WL-1:0] vals[2] = '{3'd7, 3'd4};
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, vals[i]);
      n_checks++;
      if (act_vec() !== exp_vec() || bus.sp !== N'(4) || bus.error !== 1'b1) begin
        n_fail++;
        $display("FAIL overflow_%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.data !== WL'(5) || bus.sp !== N'(3)) begin
      n_fail++;
      $display("FAIL overflow_pop: got %b want %b (data 5)", act_vec(), exp_vec());
    end
  endtask

  task automatic test_pop_sequence();
    logic [WL-1:0] want[5] = '{3'd3, 3'd4, 3'd2, 3'd1, 3'd1};
    step(1'b1, 1'b0, 3'd3);
    step(1'b1, 1'b0, 3'd1);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.error !== 1'b1 || bus.sp !== N'(4)) begin
      n_fail++;
      $display("FAIL push_full_err: got %b want %b", act_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (act_vec() !== exp_vec() || bus.data !== want[i]) begin
        n_fail++;
        $display("FAIL pop_%0d: got %b want %b (data %0d)", i, act_vec(), exp_vec(), want[i]);
      end
    end
    n_checks++;
    if (bus.error !== 1'b1 || bus.sp !== N'(0) || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: got err=%b sp=%0d want err=1 sp=0", bus.error, bus.sp);
    end
    step(1'b1, 1'b0, 3'd2);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.sp !== N'(1)) begin
      n_fail++;
      $display("FAIL push_after_underflow: got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 3'd1);
    step(1'b1, 1'b0, 3'd2);
    step(1'b1, 1'b1, 3'd6);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.data !== WL'(2) || bus.sp !== N'(2)) begin
      n_fail++;
      $display("FAIL swap_top: got %b want %b", act_vec(), exp_vec());
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.data !== WL'(6)) begin
      n_fail++;
      $display("FAIL swap_readback: got %b want %b", act_vec(), exp_vec());
    end
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 3'd5);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.sp !== N'(1) || bus.error !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_empty: got %b want %b", act_vec(), exp_vec());
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.data !== WL'(5)) begin
      n_fail++;
      $display("FAIL swap_empty_readback: got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 3'd3);
    step(1'b1, 1'b0, 3'd6);
    step(1'b1, 1'b0, 3'd7);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 3'd2);
    n_checks++;
    if (bus.sp !== N'(3) || bus.data === WL'(0)) begin
      n_fail++;
      $display("FAIL pre_reset: got sp=%0d data=%0d want sp=3 data!=0", bus.sp, bus.data);
    end
    #2;
    RESET = 1'b0;
    #1;
    q.delete();
    m_data = '0;
    m_err  = 1'b0;
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", act_vec(), exp_vec());
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WL'($urandom));
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_pop_sequence();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stack.md
Name: stack

Overview:
- Parameterised LIFO stack of WL-bit words, N entries deep.
- Has a stack-pointer output, full/empty status, an illegal-operation error flag and a registered pop-data output.
- Used as a small hardware stack, e.g. for return addresses or operands, inside the pipelined processor.

Parameters:
- N, 4: stack depth in entries; also the bit width of sp (sp counts 0..N).
- WL, 3: data word width in bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- push  input  1  push request; writes di on top of the stack.
- pop  input  1  pop request; removes the top entry into data.
- di  input  WL  data to push.
- sp  output  N  number of entries currently stored (0..N); the next free slot index.
- full  output  1  high when sp == N.
- empty  output  1  high when sp == 0.
- error  output  1  registered flag for an illegal operation in the previous cycle.
- data  output  WL  registered value of the last popped entry.

Behaviour:
- Reset (RESET low, asynchronous):
  - sp = 0, data = 0, error = 0.
  - Therefore empty = 1 and full = 0.
  - Memory contents are don't-care.
- full and empty are combinational decodes of sp.
- All other updates happen on the rising edge of CLK while RESET is high.
- Idle (push = 0, pop = 0): sp and data hold; error clears to 0.
- Push only, not full:
  - mem[sp] <= di; sp <= sp + 1; error <= 0.
- Push only, full (overflow):
  - Memory and sp unchanged; write discarded; error <= 1.
- Pop only, not empty:
  - data <= mem[sp - 1]; sp <= sp - 1; error <= 0.
- Pop only, empty (underflow):
  - sp and data unchanged; error <= 1.
- Push and pop together, not empty:
  - Top entry is replaced: data <= mem[sp - 1]; mem[sp - 1] <= di.
  - sp unchanged; error <= 0.
- Push and pop together, empty:
  - Push is performed (mem[0] <= di, sp <= 1); the pop is illegal, so error <= 1; data unchanged.
- Latency:
  - Pushed data is available to a pop on the next cycle.
  - data updates one clock after a pop is sampled.
- data holds its value until the next successful pop.
- sp never exceeds N and never wraps below 0.
- A reset asserted mid-operation immediately empties the stack and clears error, independent of CLK.

Optional Feature:
- Macro: STACK_ERR_STICKY_EN.
- Defined: error is sticky.
  - Set by any overflow or underflow; stays 1 through later legal operations until RESET.
  - Illegal operations still leave sp, memory and data unchanged, as above.
- Not defined: error reflects only the previous cycle's operation, as described in Behaviour.

Test Plan:
- Reset, then push 1, 2, 4, 5 on consecutive edges -> sp = 1, 2, 3, 4; full = 1 after the fourth push; empty = 0; error = 0.
- Full stack, push 7 then push 4 -> sp stays 4; error = 1 on both cycles; a later pop gives data = 5 (overflow writes discarded), sp = 3, error = 0.
- From sp = 3 with contents 1, 2, 4: push 3, then push 1 -> sp = 4, then error = 1. Then five pops:
  - first four give data = 3, 4, 2, 1 with sp = 3, 2, 1, 0; empty = 1 after the fourth;
  - fifth pop gives error = 1 with data still 1 and sp = 0;
  - a following push 2 gives sp = 1, error = 0.
- Simultaneous push 6 and pop with stack holding 1, 2 -> data = 2; sp stays 2; a following pop returns 6.
- Simultaneous push 5 and pop on an empty stack -> sp = 1, error = 1; a following pop returns 5.
- Assert RESET low between clock edges while sp = 3 -> sp = 0, empty = 1, error = 0, data = 0 immediately, without waiting for a clock edge.
